// File: rtl/filter_channel_scheduler.sv
// Round-robin scheduler that time-shares one 3-tap smoother y = (x + 2*d1 + d2) >> 2
// across NCH channels, each with private delay registers, behind a single registered output.

module filter_channel_scheduler_lane #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RESETN,
  input  logic         i_clr,
  input  logic         i_acc,
  input  logic [W-1:0] i_x,
  output logic [W+1:0] o_sum
);
  logic [W-1:0] r_d1, r_d2;

  // A channel is never granted while it is cleared, so clr and acc never collide here.
  always_ff @(posedge CLK) begin
    if (!RESETN || i_clr) begin
      r_d1 <= '0;
      r_d2 <= '0;
    end else if (i_acc) begin
      r_d2 <= r_d1;
      r_d1 <= i_x;
    end
  end

  assign o_sum = {2'b00, i_x} + {1'b0, r_d1, 1'b0} + {2'b00, r_d2};
endmodule

module filter_channel_scheduler #(
  parameter int NCH = 4,
  parameter int W   = 8,
  parameter int CW  = 2
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic [NCH-1:0]   in_valid,
  input  logic [NCH*W-1:0] in_data,
  output logic [NCH-1:0]   in_ready,
  input  logic [NCH-1:0]   clr,
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  output logic [CW-1:0]    out_ch,
  input  logic             out_ready
);
  logic [NCH-1:0][W-1:0] w_x;
  logic [NCH-1:0][W+1:0] w_sum;
  logic [NCH-1:0]        w_elig, w_acc;
  logic                  w_slot_free, w_gnt_any, w_hi_any, w_lo_any;
  logic [CW-1:0]         w_gnt_idx, w_hi_idx, w_lo_idx;
  logic [W+1:0]          w_sel_sum;

  logic [CW-1:0]         r_ptr;
  logic                  r_out_valid;
  logic [W-1:0]          r_out_data;
  logic [CW-1:0]         r_out_ch;

  assign w_x         = in_data;
  assign w_elig      = in_valid & ~clr;
  assign w_slot_free = ~r_out_valid | out_ready;

  // Wrap-around search: lowest eligible at or above ptr, else lowest eligible overall.
  always_comb begin
    w_hi_any = 1'b0;
    w_hi_idx = '0;
    w_lo_any = 1'b0;
    w_lo_idx = '0;
    for (int i = 0; i < NCH; i++) begin
      if (!w_hi_any && w_elig[i] && (i >= int'(r_ptr))) begin
        w_hi_any = 1'b1;
        w_hi_idx = CW'(i);
      end
      if (!w_lo_any && w_elig[i]) begin
        w_lo_any = 1'b1;
        w_lo_idx = CW'(i);
      end
    end
  end

  assign w_gnt_any = w_hi_any | w_lo_any;
  assign w_gnt_idx = w_hi_any ? w_hi_idx : w_lo_idx;

  always_comb begin
    in_ready = '0;
    if (RESETN && w_slot_free && w_gnt_any) in_ready[w_gnt_idx] = 1'b1;
  end

  assign w_acc = in_ready & in_valid;

  genvar g;
  generate
    for (g = 0; g < NCH; g++) begin : g_lane
      filter_channel_scheduler_lane #(.W(W)) u_lane (
        .CLK    (CLK),
        .RESETN (RESETN),
        .i_clr  (clr[g]),
        .i_acc  (w_acc[g]),
        .i_x    (w_x[g]),
        .o_sum  (w_sum[g])
      );
    end
  endgenerate

  assign w_sel_sum = w_sum[w_gnt_idx];

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      r_ptr       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
    end else if (|w_acc) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_sel_sum[W+1:2];
      r_out_ch    <= w_gnt_idx;
      r_ptr       <= (w_gnt_idx == CW'(NCH-1)) ? '0 : w_gnt_idx + 1'b1;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;
endmodule
